tscs_error_corrector: RTL and testbench

//  Consumer side of the test-syndrome Chien search flags. Takes per-beat location flags
//  (ALPHA_NUM roots x PARALLELISM lanes) together with the buffered received codeword bits,

---
 rtl/tscs_error_corrector_pkg.sv | 16 +
 rtl/tscs_error_corrector_loc_flag_reduce.sv | 34 +++
 rtl/tscs_error_corrector.sv | 142 ++++++++++++++
 tb/tb_tscs_error_corrector.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tscs_error_corrector_pkg.sv
// Shared constants and FSM encoding for the test-syndrome error corrector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tscs_error_corrector_pkg;

   localparam int DEF_PARALLELISM = 4;
   localparam int DEF_ALPHA_NUM   = 3;
   localparam int DEF_CNT_W       = $clog2(DEF_ALPHA_NUM + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_REPORT = 2'd2
   } state_t;

endpackage

// File: rtl/tscs_error_corrector_loc_flag_reduce.sv
// Reduces one beat of root/lane location flags into lane flips, root hits and a collision bit.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, the caller decides whether the beat counts.
module loc_flag_reduce #(
   parameter int PARALLELISM = 4,
   parameter int ALPHA_NUM   = 3
)(
   input  logic [ALPHA_NUM*PARALLELISM-1:0] alpha_loc,
   input  logic [ALPHA_NUM-1:0]             root_en,
   output logic [PARALLELISM-1:0]           flip,
   output logic [ALPHA_NUM-1:0]             root_hit,
   output logic                             collide
);

   // Walk every (root, lane) pair; a second hit on a lane or a root within
   // this beat means either two roots share a lane or one root spans two lanes.
   always_comb begin
      flip     = '0;
      root_hit = '0;
      collide  = 1'b0;
      for (int j = 0; j < PARALLELISM; j++) begin
         for (int i = 0; i < ALPHA_NUM; i++) begin
            if (alpha_loc[i + j*ALPHA_NUM] && root_en[i]) begin
               if (flip[j] || root_hit[i]) begin
                  collide = 1'b1;
               end
               flip[j]     = 1'b1;
               root_hit[i] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tscs_error_corrector.sv
// Flips Chien-flagged codeword bits and reports per-word correction success or failure.
// Latency: corrected beat 1 cycle after acceptance; out_done 1 cycle after the last beat's data.
// Backpressure: none; beats outside a word are dropped, in_ctr_init aborts any open word.
module tscs_error_corrector
   import tscs_error_corrector_pkg::*;
#(
   parameter int PARALLELISM = DEF_PARALLELISM,
   parameter int ALPHA_NUM   = DEF_ALPHA_NUM,
   parameter int CNT_W       = $clog2(ALPHA_NUM + 1)
)(
   input  logic                             clk,
   input  logic                             in_ctr_Arst_n,
   input  logic                             in_ctr_Srst,
   input  logic                             in_ctr_init,
   input  logic                             in_ctr_en,
   input  logic                             in_ctr_done,
   input  logic [CNT_W-1:0]                 in_err_cnt,
   input  logic [ALPHA_NUM*PARALLELISM-1:0] in_alpha_loc,
   input  logic [PARALLELISM-1:0]           in_data,
   output logic [PARALLELISM-1:0]           out_data,
   output logic                             out_valid,
   output logic                             out_last,
   output logic [CNT_W-1:0]                 out_corr_cnt,
   output logic                             out_done,
   output logic                             out_fail
);

   localparam logic [CNT_W:0] MAX_CNT = ALPHA_NUM[CNT_W:0];

   state_t                 state;
   state_t                 state_nxt;
   logic [CNT_W-1:0]       cnt_lat;
   logic [CNT_W-1:0]       cnt_use;
   logic [CNT_W-1:0]       hit_pop;
   logic [ALPHA_NUM-1:0]   hit;
   logic [ALPHA_NUM-1:0]   hit_base;
   logic [ALPHA_NUM-1:0]   hit_nxt;
   logic [ALPHA_NUM-1:0]   root_en;
   logic [ALPHA_NUM-1:0]   beat_hit;
   logic [PARALLELISM-1:0] flip;
   logic                   dup;
   logic                   dup_base;
   logic                   dup_nxt;
   logic                   collide;
   logic                   accept;
   logic                   report;
   logic                   fail_cond;

   // Root mask: an init beat already uses the incoming count, later beats the latched one.
   always_comb begin
      cnt_use = in_ctr_init ? in_err_cnt : cnt_lat;
      for (int i = 0; i < ALPHA_NUM; i++) begin
         root_en[i] = (i < int'(cnt_use));
      end
   end

   loc_flag_reduce #(
      .PARALLELISM (PARALLELISM),
      .ALPHA_NUM   (ALPHA_NUM)
   ) u_reduce (
      .alpha_loc (in_alpha_loc),
      .root_en   (root_en),
      .flip      (flip),
      .root_hit  (beat_hit),
      .collide   (collide)
   );

   // Sticky hit/dup tracking; init starts a fresh word so prior state is discarded.
   always_comb begin
      accept   = in_ctr_en && (in_ctr_init || (state == ST_RUN));
      report   = (state == ST_REPORT) && !in_ctr_init;
      hit_base = in_ctr_init ? '0 : hit;
      dup_base = in_ctr_init ? 1'b0 : dup;
      hit_nxt  = hit_base;
      dup_nxt  = dup_base;
      if (accept) begin
         hit_nxt = hit_base | beat_hit;
         dup_nxt = dup_base | collide | (|(hit_base & beat_hit));
      end
      hit_pop = '0;
      for (int i = 0; i < ALPHA_NUM; i++) begin
         hit_pop = hit_pop + CNT_W'(hit_nxt[i]);
      end
      fail_cond = (hit_pop != cnt_lat) || dup || ({1'b0, cnt_lat} > MAX_CNT);
   end

   // Next state: init always (re)opens a word, closing at once if done is also set.
   always_comb begin
      state_nxt = state;
      if (in_ctr_init) begin
         state_nxt = in_ctr_done ? ST_REPORT : ST_RUN;
      end else begin
         case (state)
            ST_IDLE:   state_nxt = ST_IDLE;
            ST_RUN:    if (in_ctr_done) state_nxt = ST_REPORT;
            ST_REPORT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   // State, tracking and output registers; both resets clear everything.
   always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
      if (!in_ctr_Arst_n) begin
         state        <= ST_IDLE;
         cnt_lat      <= '0;
         hit          <= '0;
         dup          <= 1'b0;
         out_data     <= '0;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         out_corr_cnt <= '0;
         out_done     <= 1'b0;
         out_fail     <= 1'b0;
      end else if (in_ctr_Srst) begin
         state        <= ST_IDLE;
         cnt_lat      <= '0;
         hit          <= '0;
         dup          <= 1'b0;
         out_data     <= '0;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         out_corr_cnt <= '0;
         out_done     <= 1'b0;
         out_fail     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (in_ctr_init) begin
            cnt_lat <= in_err_cnt;
         end
         hit          <= hit_nxt;
         dup          <= dup_nxt;
         out_data     <= accept ? (in_data ^ flip) : '0;
         out_valid    <= accept;
         out_last     <= accept && in_ctr_done;
         out_corr_cnt <= hit_pop;
         out_done     <= report;
         out_fail     <= report && fail_cond;
      end
   end

endmodule

// File: tb/tb_tscs_error_corrector.sv
// Self-checking bench: directed vector table, reset corner sequences, random words vs a count-based model.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: n/a; fixed-length stimulus, no open-ended waits.
module tb_tscs_error_corrector;

   logic        clk = 1'b0;
   logic        in_ctr_Arst_n;
   logic        in_ctr_Srst;
   logic        in_ctr_init;
   logic        in_ctr_en;
   logic        in_ctr_done;
   logic [1:0]  in_err_cnt;
   logic [11:0] in_alpha_loc;
   logic [3:0]  in_data;
   logic [3:0]  out_data;
   logic        out_valid;
   logic        out_last;
   logic [1:0]  out_corr_cnt;
   logic        out_done;
   logic        out_fail;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      string       name;
      logic        init;
      logic        en;
      logic        done;
      logic [1:0]  cnt;
      logic [11:0] loc;
      logic [3:0]  data;
      logic [9:0]  exp;
   } vec_t;

   vec_t vecs[$];

   // model state for random words
   int occ [3];
   bit col;

   tscs_error_corrector dut (
      .clk           (clk),
      .in_ctr_Arst_n (in_ctr_Arst_n),
      .in_ctr_Srst   (in_ctr_Srst),
      .in_ctr_init   (in_ctr_init),
      .in_ctr_en     (in_ctr_en),
      .in_ctr_done   (in_ctr_done),
      .in_err_cnt    (in_err_cnt),
      .in_alpha_loc  (in_alpha_loc),
      .in_data       (in_data),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_last      (out_last),
      .out_corr_cnt  (out_corr_cnt),
      .out_done      (out_done),
      .out_fail      (out_fail)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] mk(int d, int v, int l, int c, int dn, int f);
      return {4'(d), 1'(v), 1'(l), 2'(c), 1'(dn), 1'(f)};
   endfunction

   task automatic add(string nm, int i, int e, int dn, int c, int loc, int d, logic [9:0] ex);
      vec_t v;
      v.name = nm;
      v.init = 1'(i);
      v.en   = 1'(e);
      v.done = 1'(dn);
      v.cnt  = 2'(c);
      v.loc  = 12'(loc);
      v.data = 4'(d);
      v.exp  = ex;
      vecs.push_back(v);
   endtask

   task automatic drive(int i, int e, int dn, int c, int loc, int d);
      in_ctr_init  = 1'(i);
      in_ctr_en    = 1'(e);
      in_ctr_done  = 1'(dn);
      in_err_cnt   = 2'(c);
      in_alpha_loc = 12'(loc);
      in_data      = 4'(d);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string nm, logic [9:0] exp);
      logic [9:0] act;
      act = {out_data, out_valid, out_last, out_corr_cnt, out_done, out_fail};
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got data=%b valid=%b last=%b corr=%0d done=%b fail=%b, required data=%b valid=%b last=%b corr=%0d done=%b fail=%b",
                  nm, act[9:6], act[5], act[4], act[3:2], act[1], act[0],
                  exp[9:6], exp[5], exp[4], exp[3:2], exp[1], exp[0]);
      end
   endtask

   // Count-based reference: flips where any masked root flags a lane, dup when a root
   // is seen more than once in the word or a lane collects two masked roots in one beat.
   task automatic model_beat(input int c, input logic [11:0] loc, input logic [3:0] d,
                             output logic [3:0] q);
      for (int j = 0; j < 4; j++) begin
         int n;
         n = 0;
         for (int i = 0; i < c; i++) begin
            if (loc[i + 3*j]) begin
               n++;
               occ[i]++;
            end
         end
         if (n > 1) col = 1'b1;
         q[j] = d[j] ^ (n > 0);
      end
   endtask

   function automatic int model_corr();
      int n;
      n = 0;
      for (int i = 0; i < 3; i++) if (occ[i] > 0) n++;
      return n;
   endfunction

   function automatic logic [11:0] rand_loc();
      logic [11:0] l;
      for (int k = 0; k < 12; k++) l[k] = ($urandom_range(0, 5) == 0);
      return l;
   endfunction

   initial begin
      in_ctr_Arst_n = 1'b0;
      in_ctr_Srst   = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      #1;
      check("reset_async", mk(0, 0, 0, 0, 0, 0));
      step();
      step();
      check("reset_held", mk(0, 0, 0, 0, 0, 0));
      in_ctr_Arst_n = 1'b1;

      // directed vector table
      add("t1_init", 1, 0, 0, 2, 0,      0,       mk(0, 0, 0, 0, 0, 0));
      add("t1_b0",   0, 1, 0, 0, 12'h008, 4'b1010, mk(4'b1000, 1, 0, 1, 0, 0));
      add("t1_b1",   0, 1, 1, 0, 12'h400, 4'b0000, mk(4'b1000, 1, 1, 2, 0, 0));
      add("t1_rep",  0, 0, 0, 0, 0,      0,       mk(0, 0, 0, 2, 1, 0));
      add("t1_hold", 0, 0, 0, 0, 0,      0,       mk(0, 0, 0, 2, 0, 0));
      add("t2_init", 1, 0, 0, 2, 0,      0,       mk(0, 0, 0, 0, 0, 0));
      add("t2_b0",   0, 1, 0, 0, 12'h001, 4'b0000, mk(4'b0001, 1, 0, 1, 0, 0));
      add("t2_b1",   0, 1, 0, 0, 0,      4'b0110, mk(4'b0110, 1, 0, 1, 0, 0));
      add("t2_b2",   0, 1, 1, 0, 0,      4'b1111, mk(4'b1111, 1, 1, 1, 0, 0));
      add("t2_rep",  0, 0, 0, 0, 0,      0,       mk(0, 0, 0, 1, 1, 1));
      add("t3_init", 1, 0, 0, 1, 0,      0,       mk(0, 0, 0, 0, 0, 0));
      add("t3_b0",   0, 1, 1, 0, 12'h004, 4'b0101, mk(4'b0101, 1, 1, 0, 0, 0));
      add("t3_rep",  0, 0, 0, 0, 0,      0,       mk(0, 0, 0, 0, 1, 1));
      add("t4_init", 1, 0, 0, 2, 0,      0,       mk(0, 0, 0, 0, 0, 0));
      add("t4_b0",   0, 1, 1, 0, 12'h0C0, 4'b0000, mk(4'b0100, 1, 1, 2, 0, 0));
      add("t4_rep",  0, 0, 0, 0, 0,      0,       mk(0, 0, 0, 2, 1, 1));
      add("t6_first",  1, 1, 1, 1, 12'h200, 4'b0000, mk(4'b1000, 1, 1, 1, 0, 0));
      add("t6_repdrop",0, 1, 0, 0, 0,      4'b1111, mk(0, 0, 0, 1, 1, 0));
      add("t6_idledrop",0, 1, 0, 0, 0,     4'b1111, mk(0, 0, 0, 1, 0, 0));
      add("t6_init",   1, 0, 0, 2, 0,      0,       mk(0, 0, 0, 0, 0, 0));
      add("t6_b0",     0, 1, 0, 0, 12'h001, 4'b0000, mk(4'b0001, 1, 0, 1, 0, 0));
      add("t6_abort",  1, 1, 0, 1, 0,      4'b0011, mk(4'b0011, 1, 0, 0, 0, 0));
      add("t6_b1",     0, 1, 1, 0, 0,      4'b0000, mk(4'b0000, 1, 1, 0, 0, 0));
      add("t6_rep",    0, 0, 0, 0, 0,      0,       mk(0, 0, 0, 0, 1, 1));
      add("t6_idle",   0, 0, 0, 0, 0,      0,       mk(0, 0, 0, 0, 0, 0));

      foreach (vecs[k]) begin
         drive(vecs[k].init, vecs[k].en, vecs[k].done, vecs[k].cnt, vecs[k].loc, vecs[k].data);
         step();
         check(vecs[k].name, vecs[k].exp);
      end

      // async reset mid-word, then a clean word must not see stale hits
      drive(1, 0, 0, 2, 0, 0);
      step();
      drive(0, 1, 0, 0, 12'h008, 0);
      step();
      check("t5_b0", mk(4'b0010, 1, 0, 1, 0, 0));
      drive(0, 1, 0, 0, 12'h400, 0);
      step();
      check("t5_b1", mk(4'b1000, 1, 0, 2, 0, 0));
      drive(0, 0, 0, 0, 0, 0);
      #2;
      in_ctr_Arst_n = 1'b0;
      #1;
      check("t5_arst_imm", mk(0, 0, 0, 0, 0, 0));
      step();
      check("t5_arst_edge", mk(0, 0, 0, 0, 0, 0));
      in_ctr_Arst_n = 1'b1;
      drive(1, 1, 1, 1, 12'h001, 0);
      step();
      check("t5_reinit", mk(4'b0001, 1, 1, 1, 0, 0));
      drive(0, 0, 0, 0, 0, 0);
      step();
      check("t5_rep", mk(0, 0, 0, 1, 1, 0));

      // synchronous reset mid-word: clears and suppresses the report
      drive(1, 1, 0, 2, 12'h001, 0);
      step();
      check("srst_b0", mk(4'b0001, 1, 0, 1, 0, 0));
      in_ctr_Srst = 1'b1;
      drive(0, 1, 1, 0, 12'h400, 0);
      step();
      check("srst_edge", mk(0, 0, 0, 0, 0, 0));
      in_ctr_Srst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      step();
      check("srst_norep", mk(0, 0, 0, 0, 0, 0));

      // random words against the reference model
      for (int w = 0; w < 60; w++) begin
         int          cnt;
         int          nb;
         int          corr;
         logic        e;
         logic [11:0] loc;
         logic [3:0]  d;
         logic [3:0]  q;
         bit          dup;
         cnt = $urandom_range(0, 3);
         nb  = $urandom_range(1, 5);
         for (int i = 0; i < 3; i++) occ[i] = 0;
         col = 1'b0;
         for (int b = 0; b <= nb; b++) begin
            e   = (b == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
            loc = rand_loc();
            d   = 4'($urandom);
            q   = 4'b0000;
            drive((b == 0) ? 1 : 0, e, (b == nb) ? 1 : 0, cnt, loc, d);
            if (e) model_beat(cnt, loc, d, q);
            step();
            check($sformatf("rnd_w%0d_b%0d", w, b),
                  mk(e ? q : 0, e, e && (b == nb), model_corr(), 0, 0));
         end
         corr = model_corr();
         dup  = col;
         for (int i = 0; i < 3; i++) if (occ[i] > 1) dup = 1'b1;
         drive(0, $urandom_range(0, 1), 0, 0, rand_loc(), $urandom);
         step();
         check($sformatf("rnd_w%0d_rep", w), mk(0, 0, 0, corr, 1, (corr != cnt) || dup));
         drive(0, $urandom_range(0, 1), 0, 0, rand_loc(), $urandom);
         step();
         check($sformatf("rnd_w%0d_idle", w), mk(0, 0, 0, corr, 0, 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
